// File: rtl/md5_pad_pkg.sv
// md5_pad shared constants: block geometry, MD5 initial state, FSM encoding.
// Pure declarations; no logic, no latency.
// Imported by the interface, the merge helper and the padding top.
package md5_pad_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int STATE_DWIDTH = 32;
  localparam int BLOCK_WORDS  = 16;
  localparam int IDX_W        = $clog2(BLOCK_WORDS);
  localparam int LEN_WORD_IDX = 14;
  localparam int CNT_W        = 61;  // message byte count; bit length is CNT_W+3 = 64 bits

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] LEN_IDX     = IDX_W'(LEN_WORD_IDX);
  localparam logic [IDX_W-1:0] PRE_LEN_IDX = IDX_W'(LEN_WORD_IDX - 1);

  localparam logic [STATE_DWIDTH-1:0] MD5_IV_A = 32'h67452301;
  localparam logic [STATE_DWIDTH-1:0] MD5_IV_B = 32'hEFCDAB89;
  localparam logic [STATE_DWIDTH-1:0] MD5_IV_C = 32'h98BADCFE;
  localparam logic [STATE_DWIDTH-1:0] MD5_IV_D = 32'h10325476;

  // Stand-alone padding word: 0x80 in byte 0, rest zero.
  localparam logic [DATA_WIDTH-1:0] PAD_WORD = 32'h0000_0080;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IV   = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_LEN  = 3'd4,
    ST_WAIT = 3'd5
  } state_t;

  // True when the final word has a free byte lane for the 0x80 marker.
  function automatic logic last_has_pad(input logic [2:0] nbytes);
    return nbytes < 3'd4;
  endfunction

endpackage

// File: rtl/md5_pad_if.sv
// md5_pad bus bundle: message input, block/IV output to the hash core, core done.
// No logic, no latency.
// master = padding block side, slave = upstream source plus hash core side.
interface md5_pad_if;
  import md5_pad_pkg::*;

  logic                    inVld;
  logic                    inRdy;
  logic [DATA_WIDTH-1:0]   inData;
  logic                    inLast;
  logic [2:0]              inBytes;
  logic                    dataVld;
  logic [DATA_WIDTH-1:0]   dataOut;
  logic                    stateVld;
  logic [STATE_DWIDTH-1:0] stateAOut;
  logic [STATE_DWIDTH-1:0] stateBOut;
  logic [STATE_DWIDTH-1:0] stateCOut;
  logic [STATE_DWIDTH-1:0] stateDOut;
  logic                    blkDone;
  logic                    msgBusy;

  modport master (
    input  inVld, inData, inLast, inBytes, blkDone,
    output inRdy, dataVld, dataOut, stateVld,
           stateAOut, stateBOut, stateCOut, stateDOut, msgBusy
  );

  modport slave (
    output inVld, inData, inLast, inBytes, blkDone,
    input  inRdy, dataVld, dataOut, stateVld,
           stateAOut, stateBOut, stateCOut, stateDOut, msgBusy
  );

endinterface

// File: rtl/md5_pad_merge.sv
// Final-word merge: keeps the first in_bytes bytes, puts 0x80 after them, zeroes the rest.
// Combinational, zero latency.
// No handshake; in_bytes of 4 (or out-of-range 5..7) passes the word through unchanged.
module md5_pad_merge
  import md5_pad_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_bytes,
  output logic [DATA_WIDTH-1:0] merged
);

  // Byte 0 is the first message byte, so the marker lands just above the valid bytes.
  always_comb begin
    merged = in_data;
    case (in_bytes)
      3'd0:    merged = PAD_WORD;
      3'd1:    merged = {16'h0000, 8'h80, in_data[7:0]};
      3'd2:    merged = {8'h00, 8'h80, in_data[15:0]};
      3'd3:    merged = {8'h80, in_data[23:0]};
      default: merged = in_data;
    endcase
  end

endmodule

// File: rtl/md5_pad.sv
// MD5 padding feeder: IV pulse, then message words, 0x80/zero fill and 64-bit length in 16-word blocks.
// Output words are registered: dataVld/dataOut follow the accepting or padding cycle by 1 clock.
// inRdy only in DATA; a new block never starts until the core pulses blkDone (optional blkCnt via MD5_PAD_BLKCNT_EN).
module md5_pad
  import md5_pad_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef MD5_PAD_BLKCNT_EN
  output logic [15:0] blkCnt,
`endif
  md5_pad_if.master   bus
);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;            // index of the next word to emit
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                   pad80_q, pad80_d;        // 0x80 marker already emitted
  logic                   pad_pend_q, pad_pend_d;  // message ended, padding continues after WAIT
  logic                   msg_end_q, msg_end_d;    // length emitted, WAIT returns to IDLE
  logic                   data_vld_q, data_vld_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
`ifdef MD5_PAD_BLKCNT_EN
  logic [15:0]            blk_cnt_q, blk_cnt_d;
`endif

  logic                   in_rdy;
  logic                   hs;
  logic [DATA_WIDTH-1:0]  merged;
  logic [2:0]             add_bytes;
  logic [63:0]            bit_len;

  md5_pad_merge u_merge (
    .in_data  (bus.inData),
    .in_bytes (bus.inBytes),
    .merged   (merged)
  );

  assign in_rdy  = (state_q == ST_DATA);
  assign hs      = bus.inVld & in_rdy;
  assign bit_len = {byte_cnt_q, 3'b000};

  // Next-state and datapath: one word per cycle in DATA/PAD/LEN, block boundary parks in WAIT.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    pad80_d    = pad80_q;
    pad_pend_d = pad_pend_q;
    msg_end_d  = msg_end_q;
    data_vld_d = 1'b0;
    data_out_d = '0;
    add_bytes  = 3'd4;
`ifdef MD5_PAD_BLKCNT_EN
    blk_cnt_d  = blk_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.inVld) state_d = ST_IV;
      end
      ST_IV: begin
        idx_d      = '0;
        byte_cnt_d = '0;
        pad80_d    = 1'b0;
        pad_pend_d = 1'b0;
        msg_end_d  = 1'b0;
`ifdef MD5_PAD_BLKCNT_EN
        blk_cnt_d  = '0;
`endif
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (hs) begin
          add_bytes  = bus.inLast ? bus.inBytes : 3'd4;
          data_vld_d = 1'b1;
          data_out_d = bus.inLast ? merged : bus.inData;
          byte_cnt_d = byte_cnt_q + {{(CNT_W-3){1'b0}}, add_bytes};
          idx_d      = idx_q + IDX_W'(1);
          if (bus.inLast) pad80_d = last_has_pad(bus.inBytes);
          if (idx_q == LAST_IDX) begin
            state_d    = ST_WAIT;
            pad_pend_d = bus.inLast;
          end else if (bus.inLast) begin
            // Marker already in word 13: words 14/15 are free for the length.
            state_d = (idx_q == PRE_LEN_IDX && last_has_pad(bus.inBytes)) ? ST_LEN : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        data_vld_d = 1'b1;
        data_out_d = pad80_q ? '0 : PAD_WORD;
        pad80_d    = 1'b1;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // No room for the length in this block; it goes into the next one.
          state_d    = ST_WAIT;
          pad_pend_d = 1'b1;
        end else if (idx_q == PRE_LEN_IDX) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        data_vld_d = 1'b1;
        data_out_d = (idx_q == LEN_IDX) ? bit_len[31:0] : bit_len[63:32];
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d   = ST_WAIT;
          msg_end_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.blkDone) begin
`ifdef MD5_PAD_BLKCNT_EN
          if (blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
`endif
          if (msg_end_q)       state_d = ST_IDLE;
          else if (pad_pend_q) state_d = ST_PAD;
          else                 state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; synchronous reset drops any partial block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      pad80_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      msg_end_q  <= 1'b0;
      data_vld_q <= 1'b0;
      data_out_q <= '0;
`ifdef MD5_PAD_BLKCNT_EN
      blk_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      pad80_q    <= pad80_d;
      pad_pend_q <= pad_pend_d;
      msg_end_q  <= msg_end_d;
      data_vld_q <= data_vld_d;
      data_out_q <= data_out_d;
`ifdef MD5_PAD_BLKCNT_EN
      blk_cnt_q  <= blk_cnt_d;
`endif
    end
  end

  assign bus.inRdy     = in_rdy;
  assign bus.dataVld   = data_vld_q;
  assign bus.dataOut   = data_out_q;
  assign bus.stateVld  = (state_q == ST_IV);
  assign bus.stateAOut = bus.stateVld ? MD5_IV_A : '0;
  assign bus.stateBOut = bus.stateVld ? MD5_IV_B : '0;
  assign bus.stateCOut = bus.stateVld ? MD5_IV_C : '0;
  assign bus.stateDOut = bus.stateVld ? MD5_IV_D : '0;
  assign bus.msgBusy   = (state_q == ST_DATA) || (state_q == ST_PAD) ||
                         (state_q == ST_LEN)  || (state_q == ST_WAIT);
`ifdef MD5_PAD_BLKCNT_EN
  assign blkCnt        = blk_cnt_q;
`endif

endmodule

// File: tb/tb_md5_pad.sv
// Directed bench for md5_pad: empty, "abc", 55/56-byte messages, WAIT stall, mid-block reset.
// Inputs driven and outputs sampled on the falling clock edge.
// Core is modelled by explicit blkDone pulses.
module tb_md5_pad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_pad_if bus ();
`ifdef MD5_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  md5_pad dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef MD5_PAD_BLKCNT_EN
    .blkCnt (blk_cnt),
`endif
    .bus    (bus.master)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          iv_cnt = 0;
  int          iv_bad = 0;
  logic [31:0] words[$];
  logic [31:0] exp_w[16];

  // Collect every emitted block word; check IV outputs are exact on the pulse and zero otherwise.
  always @(negedge clk) begin
    if (bus.dataVld === 1'b1) words.push_back(bus.dataOut);
    if (bus.stateVld === 1'b1) begin
      iv_cnt++;
      if (bus.stateAOut !== 32'h67452301 || bus.stateBOut !== 32'hEFCDAB89 ||
          bus.stateCOut !== 32'h98BADCFE || bus.stateDOut !== 32'h10325476) iv_bad++;
    end else if (bus.stateAOut !== 32'h0 || bus.stateBOut !== 32'h0 ||
                 bus.stateCOut !== 32'h0 || bus.stateDOut !== 32'h0) begin
      iv_bad++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] wgen(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Present one word; returns at the falling edge after it was accepted.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n;
    bus.inVld   = 1'b1;
    bus.inData  = d;
    bus.inLast  = last;
    bus.inBytes = nb;
    n = 0;
    while (bus.inRdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_inRdy", {63'b0, bus.inRdy}, 64'd1);
    @(negedge clk);
    bus.inVld  = 1'b0;
    bus.inLast = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (words.size() < n && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (words.size() < n) chk("word_count", 64'(words.size()), 64'(n));
  endtask

  task automatic check_block(input string tag, input int base);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_w%0d", tag, i), {32'b0, words[base + i]}, {32'b0, exp_w[i]});
  endtask

  task automatic pulse_done();
    bus.blkDone = 1'b1;
    @(negedge clk);
    bus.blkDone = 1'b0;
  endtask

  task automatic finish_msg(input string tag);
    pulse_done();
    chk({tag, "_idle_busy"}, {63'b0, bus.msgBusy}, 64'd0);
  endtask

  task automatic run_abc(input string tag);
    iv_cnt = 0;
    words.delete();
    send(32'h00636261, 1'b1, 3'd3);
    chk({tag, "_lat_vld"}, {63'b0, bus.dataVld}, 64'd1);
    chk({tag, "_lat_dat"}, {32'b0, bus.dataOut}, 64'h80636261);
    wait_words(16);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0]  = 32'h80636261;
    exp_w[14] = 32'h00000018;
    check_block(tag, 0);
    chk({tag, "_iv"}, 64'(iv_cnt), 64'd1);
    finish_msg(tag);
  endtask

  initial begin
    int bad;
    bus.inVld   = 1'b0;
    bus.inData  = 32'h0;
    bus.inLast  = 1'b0;
    bus.inBytes = 3'd0;
    bus.blkDone = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_inRdy",    {63'b0, bus.inRdy},    64'd0);
    chk("rst_dataVld",  {63'b0, bus.dataVld},  64'd0);
    chk("rst_dataOut",  {32'b0, bus.dataOut},  64'd0);
    chk("rst_stateVld", {63'b0, bus.stateVld}, 64'd0);
    chk("rst_stateA",   {32'b0, bus.stateAOut}, 64'd0);
    chk("rst_msgBusy",  {63'b0, bus.msgBusy},  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty message
    iv_cnt = 0;
    words.delete();
    send(32'h0, 1'b1, 3'd0);
    wait_words(16);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h00000080;
    check_block("empty", 0);
    chk("empty_iv", 64'(iv_cnt), 64'd1);
    chk("empty_busy", {63'b0, bus.msgBusy}, 64'd1);
    finish_msg("empty");

    // "abc"
    run_abc("abc");

    // 55 bytes: one block, marker in word 13; stray blkDone during DATA must be ignored
    iv_cnt = 0;
    words.delete();
    for (int i = 0; i < 13; i++) begin
      send(wgen(i), 1'b0, 3'd0);
      if (i == 4) pulse_done();
    end
    send({8'hAA, 8'h36, 8'h35, 8'h34}, 1'b1, 3'd3);
    wait_words(16);
    for (int i = 0; i < 13; i++) exp_w[i] = wgen(i);
    exp_w[13] = 32'h80363534;
    exp_w[14] = 32'h000001B8;
    exp_w[15] = 32'h0;
    check_block("m55", 0);
    repeat (3) @(negedge clk);
    chk("m55_hold_busy", {63'b0, bus.msgBusy}, 64'd1);
    chk("m55_hold_rdy",  {63'b0, bus.inRdy},   64'd0);
    chk("m55_iv", 64'(iv_cnt), 64'd1);
    finish_msg("m55");

    // 56 bytes: two blocks, second held back 100 cycles
    iv_cnt = 0;
    words.delete();
    for (int i = 0; i < 13; i++) send(wgen(i), 1'b0, 3'd0);
    send(wgen(13), 1'b1, 3'd4);
    wait_words(16);
    for (int i = 0; i < 14; i++) exp_w[i] = wgen(i);
    exp_w[14] = 32'h00000080;
    exp_w[15] = 32'h0;
    check_block("m56b1", 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.inRdy !== 1'b0 || bus.dataVld !== 1'b0) bad++;
    end
    chk("m56_wait_quiet", 64'(bad), 64'd0);
    chk("m56_wait_count", 64'(words.size()), 64'd16);
    pulse_done();
    chk("m56_resume_gap", {63'b0, bus.dataVld}, 64'd0);
    @(negedge clk);
    chk("m56_resume_vld", {63'b0, bus.dataVld}, 64'd1);
    wait_words(32);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[14] = 32'h000001C0;
    check_block("m56b2", 16);
    chk("m56_iv", 64'(iv_cnt), 64'd1);
    finish_msg("m56");

    // Reset in the middle of a block, then a clean "abc"
    words.delete();
    for (int i = 0; i < 7; i++) send(wgen(i), 1'b0, 3'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_inRdy",    {63'b0, bus.inRdy},    64'd0);
    chk("mrst_dataVld",  {63'b0, bus.dataVld},  64'd0);
    chk("mrst_dataOut",  {32'b0, bus.dataOut},  64'd0);
    chk("mrst_stateVld", {63'b0, bus.stateVld}, 64'd0);
    chk("mrst_msgBusy",  {63'b0, bus.msgBusy},  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_abc("abc2");

    chk("iv_values", 64'(iv_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
